// File: rtl/llc_axi_line_writer_if.sv
// ---------------------------------------------------------------------------
// llc_axi_line_writer_if
//   AXI4 write-address, write-data and write-response channels used by the
//   LLC line writer to push one cache line to memory.
//
//   master modport : drives AW*/W*/BREADY, samples AWREADY/WREADY/B*
//   slave  modport : the memory side, mirror image of master
// ---------------------------------------------------------------------------
interface llc_axi_line_writer_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // AW channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    // W channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // B channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/llc_axi_line_writer.sv
// ---------------------------------------------------------------------------
// llc_axi_line_writer
//   Writes one cache line to memory as a single INCR burst of
//   LINE_WIDTH/DATA_WIDTH beats over AXI4. One write outstanding at a time.
//
//   Ports
//     clk, reset     : clock, synchronous active-low reset
//     S_W_VALID/READY: line write request handshake from the LLC side
//     S_W_ADDR       : line byte address (offset bits ignored)
//     S_W_DATA       : line data, lowest 64 bits go to the lowest address
//     S_W_DONE       : one-cycle completion pulse
//     S_W_ERR        : bresp[1] of the completed write, valid with S_W_DONE
//     m_axi          : AXI4 AW/W/B master channels
// ---------------------------------------------------------------------------
module llc_axi_line_writer #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  LINE_WIDTH = 512,
    parameter logic [ID_WIDTH-1:0] WRITE_ID   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   S_W_VALID,
    output logic                   S_W_READY,
    input  logic [ADDR_WIDTH-1:0]  S_W_ADDR,
    input  logic [LINE_WIDTH-1:0]  S_W_DATA,
    output logic                   S_W_DONE,
    output logic                   S_W_ERR,
    llc_axi_line_writer_if.master  m_axi
);

    localparam int BEATS  = LINE_WIDTH / DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_t;

    state_t                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic                   ready_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   wlast_q;
    logic                   bready_q;
    logic                   done_q;
    logic                   err_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  line_q;

    logic accept;
    assign accept = S_W_VALID && ready_q;

    // Control FSM; every handshake output is a register updated together
    // with the state so it changes exactly on the transition edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            ready_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q   <= 1'b0;
                        awvalid_q <= 1'b1;
                        state_q   <= AW;
                    end
                end
                AW: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        wlast_q   <= (LAST_BEAT == '0);
                        state_q   <= W;
                    end
                end
                W: begin
                    if (m_axi.wready) begin
                        if (beat_q == LAST_BEAT) begin
                            // Counter stays on the last beat; it is cleared on the next W entry.
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= B;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            wlast_q <= (beat_q == LAST_BEAT - 1'b1);
                        end
                    end
                end
                B: begin
                    if (m_axi.bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= m_axi.bresp[1];
                        ready_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    wlast_q   <= 1'b0;
                    bready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Request capture; held until the next accept so later changes on the
    // request bus cannot leak into an in-flight burst.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= {S_W_ADDR[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            line_q <= S_W_DATA;
        end
    end

    assign S_W_READY = ready_q;
    assign S_W_DONE  = done_q;
    assign S_W_ERR   = err_q;

    assign m_axi.awid    = WRITE_ID;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = 8'(BEATS - 1);
    assign m_axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0000;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = line_q[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wlast_q;
    assign m_axi.wvalid  = wvalid_q;

    assign m_axi.bready  = bready_q;

    // Response ID and bresp[0] carry no information for a single-ID master.
    logic unused_ok;
    assign unused_ok = ^{m_axi.bid, m_axi.bresp[0], S_W_ADDR[OFF_W-1:0]};

endmodule

// File: tb/tb_llc_axi_line_writer.sv
// ---------------------------------------------------------------------------
// tb_llc_axi_line_writer
//   Self-checking bench for llc_axi_line_writer: a table of directed write
//   transactions, hand sequences for back-to-back and reset mid-burst, and
//   randomized transactions checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_llc_axi_line_writer;

    logic         clk;
    logic         reset;
    logic         S_W_VALID;
    logic         S_W_READY;
    logic [63:0]  S_W_ADDR;
    logic [511:0] S_W_DATA;
    logic         S_W_DONE;
    logic         S_W_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    llc_axi_line_writer_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) m_axi ();

    llc_axi_line_writer #(
        .ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(512), .WRITE_ID(13'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .S_W_VALID(S_W_VALID),
        .S_W_READY(S_W_READY),
        .S_W_ADDR(S_W_ADDR),
        .S_W_DATA(S_W_DATA),
        .S_W_DONE(S_W_DONE),
        .S_W_ERR(S_W_ERR),
        .m_axi(m_axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] base;
        int          aw_delay;
        logic [15:0] wpat;
        int          b_delay;
        logic [1:0]  bresp;
        bit          scramble;
        logic [63:0] exp_awaddr;
        int          exp_edges;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base * 64'(i + 1);
        return l;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Transaction-level model: cycles from the accept edge until DONE is visible.
    function automatic int model_edges(input int aw_delay, input logic [15:0] wpat, input int b_delay);
        int k, hs;
        k = 0;
        hs = 0;
        while (hs < 8) begin
            if (k >= 16 || wpat[k]) hs++;
            k++;
        end
        return (aw_delay + 1) + k + (b_delay + 1);
    endfunction

    task automatic clear_slave();
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        m_axi.bvalid  = 1'b0;
        m_axi.bresp   = 2'b00;
    endtask

    task automatic start_req(input logic [63:0] addr, input logic [511:0] line);
        int k;
        k = 0;
        while (!S_W_READY && k < 50) begin
            step();
            k++;
        end
        check("accept_ready", S_W_READY, 1'b1);
        S_W_VALID = 1'b1;
        S_W_ADDR  = addr;
        S_W_DATA  = line;
        step();
        S_W_VALID = 1'b0;
    endtask

    // Plays the memory side from just after the accept edge until one cycle
    // past DONE, checking every visible output cycle by cycle.
    task automatic run_txn(input logic [63:0] exp_awaddr, input logic [511:0] line,
                           input int aw_delay, input logic [15:0] wpat, input int b_delay,
                           input logic [1:0] bresp, input int exp_edges, input logic exp_err,
                           input bit scramble);
        int edges, awc, wc, bc, beat;
        bit aw_done, const_done, done_seen;
        edges = 0; awc = 0; wc = 0; bc = 0; beat = 0;
        aw_done = 0; const_done = 0; done_seen = 0;
        while (!done_seen && edges < 400) begin
            if (S_W_DONE) begin
                done_seen = 1;
                check("done_latency", edges, exp_edges);
                check("done_err", S_W_ERR, exp_err);
                check("w_handshakes", beat, 8);
                check("ready_at_done", S_W_READY, 1'b1);
                clear_slave();
            end else begin
                check("ready_busy", S_W_READY, 1'b0);
                if (m_axi.wvalid) begin
                    check("w_after_aw", aw_done, 1'b1);
                    if (beat < 8) begin
                        check("wdata", m_axi.wdata, line[beat*64 +: 64]);
                        check("wlast", m_axi.wlast, beat == 7);
                    end else begin
                        check("w_extra_beat", beat, 7);
                    end
                    m_axi.wready = (wc >= 16) ? 1'b1 : wpat[wc];
                    wc++;
                    if (m_axi.wready) beat++;
                end else begin
                    m_axi.wready = 1'b0;
                    check("wlast_idle", m_axi.wlast, 1'b0);
                end
                if (m_axi.awvalid) begin
                    check("aw_once", aw_done, 1'b0);
                    check("awaddr", m_axi.awaddr, exp_awaddr);
                    if (!const_done) begin
                        const_done = 1;
                        check("awid", m_axi.awid, 0);
                        check("awlen", m_axi.awlen, 7);
                        check("awsize", m_axi.awsize, 3);
                        check("awburst", m_axi.awburst, 1);
                        check("aw_lock_cache_prot", {m_axi.awlock, m_axi.awcache, m_axi.awprot}, 0);
                        check("wstrb", m_axi.wstrb, 8'hFF);
                    end
                    m_axi.awready = (awc >= aw_delay);
                    awc++;
                    if (m_axi.awready) aw_done = 1;
                end else begin
                    m_axi.awready = 1'b0;
                end
                if (m_axi.bready) begin
                    check("b_after_w", beat, 8);
                    m_axi.bvalid = (bc >= b_delay);
                    m_axi.bresp  = m_axi.bvalid ? bresp : 2'b00;
                    bc++;
                end else begin
                    m_axi.bvalid = 1'b0;
                end
                if (scramble) begin
                    S_W_ADDR = {$urandom, $urandom};
                    S_W_DATA = rand_line();
                end
            end
            step();
            edges++;
        end
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no DONE after %0d cycles, expected after %0d", edges, exp_edges);
            clear_slave();
        end else begin
            check("done_pulse_width", S_W_DONE, 1'b0);
            check("err_after_done", S_W_ERR, 1'b0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [511:0] line;
        line = mk_line(v.base);
        start_req(v.addr, line);
        run_txn(v.exp_awaddr, line, v.aw_delay, v.wpat, v.b_delay, v.bresp,
                v.exp_edges, v.exp_err, v.scramble);
    endtask

    initial begin
        logic [511:0] l1, l2;
        vec_t rv;

        vecs[0] = '{64'h0000_0000_8000_1234, 64'h1111_1111_1111_1111, 0, 16'hFFFF, 0, 2'b00, 1'b0,
                    64'h0000_0000_8000_1200, 10, 1'b0};
        vecs[1] = '{64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF, 5, 16'h9249, 0, 2'b01, 1'b0,
                    64'h0000_0000_DEAD_BEC0, 25, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_0040, 64'hA5A5_A5A5_A5A5_A5A5, 0, 16'hFFFF, 3, 2'b10, 1'b0,
                    64'h0000_0000_0000_0040, 13, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_1234_5678_9ABC, 2, 16'hFFFE, 1, 2'b11, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFC0, 14, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_CAFE_F00D, 1, 16'hFFFF, 0, 2'b00, 1'b1,
                    64'h1234_5678_9ABC_DEC0, 11, 1'b0};

        reset     = 1'b0;
        S_W_VALID = 1'b0;
        S_W_ADDR  = '0;
        S_W_DATA  = '0;
        m_axi.bid = '0;
        clear_slave();

        // Reset state
        repeat (3) step();
        check("rst_ready", S_W_READY, 1'b0);
        check("rst_awvalid", m_axi.awvalid, 1'b0);
        check("rst_wvalid", m_axi.wvalid, 1'b0);
        check("rst_wlast", m_axi.wlast, 1'b0);
        check("rst_bready", m_axi.bready, 1'b0);
        check("rst_done", S_W_DONE, 1'b0);
        check("rst_err", S_W_ERR, 1'b0);
        reset = 1'b1;
        step();
        check("ready_after_release", S_W_READY, 1'b1);

        // Directed table
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Back-to-back: second request held valid through the first write
        l1 = mk_line(64'h0101_0202_0303_0404);
        l2 = mk_line(64'h7777_0000_7777_0001);
        start_req(64'h0000_0000_1000_0080, l1);
        S_W_VALID = 1'b1;
        S_W_ADDR  = 64'h40;
        S_W_DATA  = l2;
        run_txn(64'h0000_0000_1000_0080, l1, 0, 16'hFFFF, 0, 2'b00, 10, 1'b0, 1'b0);
        check("b2b_awvalid", m_axi.awvalid, 1'b1);
        check("b2b_awaddr", m_axi.awaddr, 64'h40);
        S_W_VALID = 1'b0;
        run_txn(64'h40, l2, 0, 16'hFFFF, 0, 2'b00, 10, 1'b0, 1'b0);

        // Reset after three W beats
        l1 = mk_line(64'h5555_AAAA_5555_AAAA);
        start_req(64'h0000_0000_0000_2000, l1);
        m_axi.awready = 1'b1;
        step();
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b1;
        repeat (3) step();
        check("rst_mid_wvalid_before", m_axi.wvalid, 1'b1);
        check("rst_mid_wdata_before", m_axi.wdata, l1[3*64 +: 64]);
        reset = 1'b0;
        m_axi.wready = 1'b0;
        step();
        check("rst_mid_wvalid", m_axi.wvalid, 1'b0);
        check("rst_mid_awvalid", m_axi.awvalid, 1'b0);
        check("rst_mid_bready", m_axi.bready, 1'b0);
        check("rst_mid_ready", S_W_READY, 1'b0);
        check("rst_mid_done", S_W_DONE, 1'b0);
        step();
        check("rst_mid_done2", S_W_DONE, 1'b0);
        reset = 1'b1;
        step();
        check("rst_mid_ready_release", S_W_READY, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_no_done", S_W_DONE, 1'b0);
            check("rst_mid_no_wvalid", m_axi.wvalid, 1'b0);
            step();
        end
        run_vec(vecs[0]);

        // Randomized transactions against the model
        for (int n = 0; n < 20; n++) begin
            rv.addr       = {$urandom, $urandom};
            rv.aw_delay   = $urandom_range(0, 4);
            rv.wpat       = 16'($urandom);
            rv.b_delay    = $urandom_range(0, 4);
            rv.bresp      = 2'($urandom_range(0, 3));
            rv.scramble   = 1'b1;
            rv.exp_awaddr = {rv.addr[63:6], 6'b0};
            rv.exp_edges  = model_edges(rv.aw_delay, rv.wpat, rv.b_delay);
            rv.exp_err    = (rv.bresp == 2'b10) || (rv.bresp == 2'b11);
            l1 = rand_line();
            start_req(rv.addr, l1);
            run_txn(rv.exp_awaddr, l1, rv.aw_delay, rv.wpat, rv.b_delay, rv.bresp,
                    rv.exp_edges, rv.exp_err, rv.scramble);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
